led_pwm_fader: RTL and testbench
================================

LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_DIV, default 1, clk cycles per PWM counter step (>=1).
REQ-002 SHALL have parameter FADE_DIV, default 2_500_000, clk cycles per fade tick (>=1).
REQ-003 SHALL have parameter FADE_STEP, default 16, duty decrement per fade tick (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port led_in  input  8  one-hot running-light pattern from the upstream rotator.
REQ-007 SHALL have port bright  input  8  global peak duty; 0 = off, 255 = fully on.
REQ-008 SHALL have port led_out  output  8  registered PWM drive to the board LEDs.

Function
REQ-009 SHALL run prescaler pre_cnt 0..PWM_DIV-1; pwm_tick asserts in the cycle pre_cnt == PWM_DIV-1, then pre_cnt wraps to 0.
REQ-010 SHALL advance 8-bit pwm_cnt by 1 on each pwm_tick, wrapping 255 -> 0.
REQ-011 SHALL run fade counter 0..FADE_DIV-1, independent of the prescaler; fade_tick asserts in the cycle it equals FADE_DIV-1.
REQ-012 SHALL hold an 8-bit duty[i] per channel; when led_in[i]=1, duty[i] <= bright every cycle (tracks bright changes).
REQ-013 SHALL, when led_in[i]=0 and fade_tick=1, set duty[i] <= duty[i]-FADE_STEP if duty[i] > FADE_STEP, else 0 (saturate, no wrap).
REQ-014 SHALL give led_in[i]=1 priority over a coincident fade_tick: no decrement that cycle.
REQ-015 SHALL hold duty[i] unchanged when led_in[i]=0 and fade_tick=0.
REQ-016 SHALL register led_out[i] <= (duty[i]==255) | (pwm_cnt < duty[i]); duty 0 gives constant 0, duty 255 gives constant 1.
REQ-017 SHALL have latency led_in edge -> duty update 1 cycle, -> led_out reflecting new duty 2 cycles.
REQ-018 SHALL treat all 8 channels identically; any led_in pattern, including non-one-hot and all-zero, is legal.

Reset
REQ-019 SHALL, on rst=1 at a clk edge, set pre_cnt=0, pwm_cnt=0, fade counter=0, all duty[i]=0, led_out=8'h00.
REQ-020 SHALL give rst priority over all other updates, including mid-fade and mid-PWM-period.
REQ-021 SHALL resume counting from 0 in the first cycle after rst deasserts.

Configuration
REQ-022 SHALL use macro LED_FADE_EN to enable the fade tail.
REQ-023 SHALL, with LED_FADE_EN defined, implement REQ-011..REQ-015 as written.
REQ-024 SHALL, without LED_FADE_EN, omit the fade counter and set duty[i] <= led_in[i] ? bright : 0 every cycle; FADE_DIV/FADE_STEP are ignored.

Structure
REQ-025 SHALL place PWM_W=8 and the duty/channel width constants in shared package led_pkg.
REQ-026 SHALL implement per-channel duty register, fade decrement and compare in sub-module led_pwm_channel, instanced 8 times; prescaler, pwm_cnt and fade counter live in led_pwm_fader.

Verification
REQ-027 SHALL cover: rst=1 for 3 cycles mid-operation -> led_out=8'h00, all duty=0, pwm_cnt=0 next cycle.
REQ-028 SHALL cover: PWM_DIV=1, bright=128, led_in=8'h01 held -> led_out[0]=1 for exactly 128 of each 256 cycles, led_out[7:1]=0.
REQ-029 SHALL cover: bright=255, led_in=8'h01 -> led_out[0] constantly 1 from 2 cycles after led_in rises.
REQ-030 SHALL cover (LED_FADE_EN): FADE_DIV=4, FADE_STEP=64, bright=200, led_in 8'h01 -> 8'h02 -> duty[0] 200,136,72,8,0 on successive fade ticks, stays 0; duty[1]=200.
REQ-031 SHALL cover: led_in[0] rising in the same cycle as fade_tick with duty[0]=40, bright=100 -> duty[0]=100, no decrement.
REQ-032 SHALL cover (no LED_FADE_EN): led_in 8'h01 -> 8'h00 with bright=200 -> duty[0]=0 one cycle later, led_out[0]=0 two cycles later.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED PWM fader.
// Configuration macro: LED_FADE_EN (enables the fade tail on each channel).
package led_pkg;

  localparam int PWM_W  = 8;
  localparam int DUTY_W = 8;
  localparam int NUM_CH = 8;

  localparam logic [DUTY_W-1:0] DUTY_MAX  = 8'hFF;
  localparam logic [DUTY_W-1:0] DUTY_ZERO = 8'h00;

  // Saturating subtract: a - b when a > b, otherwise zero (never wraps).
  function automatic logic [DUTY_W-1:0] sat_sub(input logic [DUTY_W-1:0] a,
                                                input logic [DUTY_W-1:0] b);
    logic [DUTY_W-1:0] res;
    if (a > b) begin
      res = a - b;
    end else begin
      res = DUTY_ZERO;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty register, optional fade decrement and PWM compare.
// Configuration macro: LED_FADE_EN (fade tail); without it duty follows
// led_in directly (bright when lit, zero when not).
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int FADE_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              led_in,
  input  logic [DUTY_W-1:0] bright,
  input  logic              fade_tick,
  input  logic [PWM_W-1:0]  pwm_cnt,
  output logic              led_out
);

  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_nxt_s;
  logic              led_r;

`ifdef LED_FADE_EN
  localparam logic [DUTY_W-1:0] STEP_C = DUTY_W'(FADE_STEP);

  // Next duty: a lit input tracks bright and wins over a fade tick.
  always_comb begin
    duty_nxt_s = duty_r;
    if (led_in) begin
      duty_nxt_s = bright;
    end else if (fade_tick) begin
      duty_nxt_s = sat_sub(duty_r, STEP_C);
    end else begin
      duty_nxt_s = duty_r;
    end
  end
`else
  localparam int unused_fade_step = FADE_STEP;
  logic unused_fade_tick_s;
  assign unused_fade_tick_s = fade_tick;

  // Next duty without fade: bright while lit, dark otherwise.
  always_comb begin
    duty_nxt_s = duty_r;
    if (led_in) begin
      duty_nxt_s = bright;
    end else begin
      duty_nxt_s = DUTY_ZERO;
    end
  end
`endif

  // Duty register and registered PWM compare; full duty forces a steady on.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r <= DUTY_ZERO;
      led_r  <= 1'b0;
    end else begin
      duty_r <= duty_nxt_s;
      led_r  <= (duty_r == DUTY_MAX) || (pwm_cnt < duty_r);
    end
  end

  assign led_out = led_r;

endmodule

// File: rtl/led_pwm_fader.sv
// Eight-channel LED PWM driver with an optional fading tail.
// Holds the shared PWM prescaler, PWM counter and fade-tick counter.
// Configuration macro: LED_FADE_EN (fade counter and per-channel fade tail).
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int PWM_DIV   = 1,
  parameter int FADE_DIV  = 2_500_000,
  parameter int FADE_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] led_in,
  input  logic [DUTY_W-1:0] bright,
  output logic [NUM_CH-1:0] led_out
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_r;
  logic             pwm_tick_s;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic             fade_tick_s;

  assign pwm_tick_s = (pre_cnt_r == PRE_LAST);

  // Prescaler and free-running PWM counter (wraps 255 -> 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      pwm_cnt_r <= {PWM_W{1'b0}};
    end else if (pwm_tick_s) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

`ifdef LED_FADE_EN
  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

  logic [FADE_W-1:0] fade_cnt_r;

  assign fade_tick_s = (fade_cnt_r == FADE_LAST);

  // Fade tick counter, independent of the PWM prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      fade_cnt_r <= {FADE_W{1'b0}};
    end else if (fade_tick_s) begin
      fade_cnt_r <= {FADE_W{1'b0}};
    end else begin
      fade_cnt_r <= fade_cnt_r + FADE_W'(1);
    end
  end
`else
  localparam int unused_fade_div = FADE_DIV;
  assign fade_tick_s = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_channel #(
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .led_in    (led_in[i]),
      .bright    (bright),
      .fade_tick (fade_tick_s),
      .pwm_cnt   (pwm_cnt_r),
      .led_out   (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: a cycle-indexed arithmetic model
// predicts led_out for every clock edge; a monitor compares after each edge.
module tb_led_pwm_fader;

  localparam int PWM_DIV   = 2;
  localparam int FADE_DIV  = 4;
  localparam int FADE_STEP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led_in = 8'h00;
  logic [7:0] bright = 8'h00;
  logic [7:0] led_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_duty[8];
  int         m_t = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PWM_DIV   (PWM_DIV),
    .FADE_DIV  (FADE_DIV),
    .FADE_STEP (FADE_STEP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in),
    .bright  (bright),
    .led_out (led_out)
  );

  // Duty rule for one channel at one clock edge.
  function automatic logic [7:0] duty_after(input logic [7:0] d, input logic li,
                                            input logic [7:0] br, input logic ft);
`ifdef LED_FADE_EN
    if (li) return br;
    if (ft) return (int'(d) > FADE_STEP) ? 8'(int'(d) - FADE_STEP) : 8'd0;
    return d;
`else
    if (li) return br;
    return 8'd0;
`endif
  endfunction

  // Apply one cycle of inputs and queue the led_out expected after that edge.
  // m_t is the number of non-reset edges since the last reset edge.
  task automatic step(input logic r, input logic [7:0] li, input logic [7:0] br);
    logic [7:0] e;
    int         pwm;
    logic       ft;
    @(negedge clk);
    rst    = r;
    led_in = li;
    bright = br;
    e = 8'h00;
    if (r) begin
      for (int i = 0; i < 8; i++) m_duty[i] = 8'h00;
      m_t = 0;
    end else begin
      pwm = (m_t / PWM_DIV) % 256;
      ft  = ((m_t % FADE_DIV) == (FADE_DIV - 1));
      for (int i = 0; i < 8; i++) begin
        e[i]      = (m_duty[i] == 8'd255) || (pwm < int'(m_duty[i]));
        m_duty[i] = duty_after(m_duty[i], li[i], br, ft);
      end
      m_t = m_t + 1;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one prediction is consumed after every clock edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        if (led_out !== e) begin
          failures = failures + 1;
          $display("FAIL led_out at %0t: got %h expected %h", $time, led_out, e);
        end
      end
    end
  end

  initial begin
    int         hi0;
    int         hi_other;
    logic [7:0] cur_li;
    logic [7:0] cur_br;

    // Power-on reset, three cycles.
    repeat (3) step(1'b1, 8'h00, 8'h00);

    // Half duty on channel 0: exactly half of one full PWM period is high.
    hi0 = 0;
    hi_other = 0;
    for (int k = 0; k < 520; k++) begin
      step(1'b0, 8'h01, 8'd128);
      if (k >= 8) begin
        if (led_out[0] === 1'b1) hi0 = hi0 + 1;
        if (led_out[7:1] !== 7'h00) hi_other = hi_other + 1;
      end
    end
    checks = checks + 1;
    if (hi0 != 256) begin
      failures = failures + 1;
      $display("FAIL half_duty_high_count got %0d expected 256", hi0);
    end
    checks = checks + 1;
    if (hi_other != 0) begin
      failures = failures + 1;
      $display("FAIL idle_channels_lit got %0d expected 0", hi_other);
    end

    // Full brightness: steady on two cycles after led_in rises.
    step(1'b0, 8'h00, 8'd255);
    step(1'b0, 8'h00, 8'd255);
    repeat (40) step(1'b0, 8'h01, 8'd255);

    // Reset mid-operation for three cycles.
    repeat (3) step(1'b1, 8'h01, 8'd255);

    // Hand-over 0x01 -> 0x02 at bright 200, then let channel 0 decay.
    repeat (5) step(1'b0, 8'h01, 8'd200);
    repeat (30) step(1'b0, 8'h02, 8'd200);

    // led_in[0] rises exactly on a fade tick while duty[0] is 40.
    repeat (2) step(1'b0, 8'h01, 8'd40);
    while ((m_t % FADE_DIV) != (FADE_DIV - 2)) step(1'b0, 8'h01, 8'd40);
    step(1'b0, 8'h00, 8'd100);
    step(1'b0, 8'h01, 8'd100);
    repeat (12) step(1'b0, 8'h00, 8'd100);

    // Release at bright 200: channel 0 goes dark (immediately or via fade).
    repeat (4) step(1'b0, 8'h01, 8'd200);
    repeat (20) step(1'b0, 8'h00, 8'd200);

    // Randomized traffic, occasional resets and held patterns.
    cur_li = 8'h01;
    cur_br = 8'd150;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_li = 8'h00;
          1: cur_li = 8'h01 << $urandom_range(0, 7);
          2: cur_li = 8'($urandom);
          default: cur_li = 8'hFF;
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_br = 8'd0;
          1: cur_br = 8'd255;
          default: cur_br = 8'($urandom);
        endcase
      end
      step(($urandom_range(0, 299) == 0), cur_li, cur_br);
    end

    // Drain the scoreboard.
    @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
